serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only while idle.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend; latched on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend; latched on an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid new results.
REQ-009 The block SHALL have port diff, output, WIDTH bits: a - b modulo 2^WIDTH.
REQ-010 The block SHALL have port borrow_out, output, 1 bit: unsigned borrow (high when a < b unsigned).
REQ-011 The block SHALL have port overflow, output, 1 bit: two's-complement signed overflow of a - b.

Function
REQ-012 The block SHALL implement the FSM states IDLE and RUN, plus a bit counter of ceil(log2(WIDTH)) bits.
REQ-013 In IDLE with start high at edge E0, the block SHALL latch a and b into shift registers, set the carry register to 1, clear the counter, and move to RUN; busy SHALL be high from E0 onward.
REQ-014 In RUN, each edge SHALL process one bit, LSB first, using full-adder equations on (a_k, NOT b_k, carry): sum = a_k XOR NOT b_k XOR carry; carry' = majority(a_k, NOT b_k, carry).
REQ-015 Each sum bit SHALL shift into the result register from the MSB end, so that bit k lands at diff[k] after WIDTH shifts.
REQ-016 At edge E0+WIDTH, the block SHALL commit the outputs as follows: diff <= assembled result; borrow_out <= NOT final carry; overflow <= (a[W-1] != b[W-1]) AND (diff[W-1] != a[W-1]), using the latched operands.
REQ-017 At edge E0+WIDTH, the block SHALL also set done <= 1 and busy <= 0 and return to IDLE; latency from start to done SHALL be exactly WIDTH cycles.
REQ-018 done SHALL be high for exactly one cycle per accepted start.
REQ-019 diff, borrow_out and overflow SHALL hold their values until the next commit or reset.
REQ-020 When start is high while busy, the block SHALL ignore it, with no effect on the operation in progress or its operands.
REQ-021 When start is high in the cycle done is high, it SHALL be accepted (back-to-back operation; zero idle cycles required).
REQ-022 Changes on a and b after acceptance SHALL NOT affect the result.
REQ-023 When a == b, the result SHALL be diff = 0, borrow_out = 0, overflow = 0.

Reset
REQ-024 When rst is high at an edge, the block SHALL go to IDLE and set busy = 0, done = 0, diff = 0, borrow_out = 0, overflow = 0, and clear the counter and carry.
REQ-025 rst SHALL take priority over start in the same cycle.
REQ-026 rst during RUN SHALL abort the operation: no done pulse for the aborted operation, and the previous results are lost (outputs read 0).

Verification (WIDTH = 32)
REQ-027 The bench SHALL cover: a=5, b=3, start one cycle -> done exactly 32 cycles later; diff=0x00000002, borrow_out=0, overflow=0.
REQ-028 The bench SHALL cover: a=3, b=5 -> diff=0xFFFFFFFE, borrow_out=1, overflow=0.
REQ-029 The bench SHALL cover: a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, borrow_out=0, overflow=1; and a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, borrow_out=1, overflow=1.
REQ-030 The bench SHALL cover: start with a=10, b=4, then start pulsed again with a=1, b=1 at cycle 5 while busy -> single done, diff=0x00000006; then start held during the done cycle with a=1, b=1 -> second done 32 cycles later, diff=0, all flags 0.
REQ-031 The bench SHALL cover: rst asserted at cycle 10 of an operation -> busy, done and all outputs 0 next cycle; no done pulse appears within 40 following cycles.
REQ-032 The bench SHALL cover randomized: 1000 random a/b pairs, each checked against a - b, the unsigned compare and the signed-overflow formula, with done-to-start latency checked at 32 every time.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle for the bit-serial subtractor
//
// Ports (per modport):
//   master : drives start, a, b; observes busy, done, diff, borrow_out, overflow
//   slave  : observes start, a, b; drives busy, done, diff, borrow_out, overflow
//   start      - request a subtraction (only honoured while idle)
//   a, b       - minuend / subtrahend, captured when start is accepted
//   busy       - operation in progress
//   done       - one-cycle pulse, new results valid
//   diff       - a - b modulo 2^WIDTH
//   borrow_out - unsigned borrow (a < b)
//   overflow   - signed two's-complement overflow of a - b

interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, one bit per clock, LSB first
//
// Ports:
//   clk - clock, all state changes on the rising edge
//   rst - synchronous active-high reset, wins over start
//   bus - serial_subtractor_if.slave (start/a/b in, busy/done/diff/flags out)
//
// Subtraction is done as a + ~b + 1: the carry register is seeded with 1 and
// every cycle one full-adder step consumes a_k and ~b_k. The result is
// assembled MSB-first into a shift register so that after WIDTH steps bit k
// sits at position k. Results are committed on the last step together with
// the done pulse, so latency from the accepting edge to done is WIDTH cycles.

module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  serial_subtractor_if.slave bus
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               carry;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  // Upper WIDTH-1 bits of the partial result; the newest sum bit is kept
  // only in res_next until it is shifted in.
  logic [WIDTH-2:0]   res_part;
  // Sign bits of the captured operands, needed at commit after the shift
  // registers have been drained.
  logic               a_msb;
  logic               b_msb;

  logic               nb_bit;
  logic               sum_bit;
  logic               carry_next;
  logic [WIDTH-1:0]   res_next;

  always_comb begin
    nb_bit     = ~b_sh[0];
    sum_bit    = a_sh[0] ^ nb_bit ^ carry;
    carry_next = (a_sh[0] & nb_bit) | (a_sh[0] & carry) | (nb_bit & carry);
    res_next   = {sum_bit, res_part};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      carry          <= 1'b0;
      a_sh           <= '0;
      b_sh           <= '0;
      res_part       <= '0;
      a_msb          <= 1'b0;
      b_msb          <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.diff       <= '0;
      bus.borrow_out <= 1'b0;
      bus.overflow   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            a_msb    <= bus.a[WIDTH-1];
            b_msb    <= bus.b[WIDTH-1];
            carry    <= 1'b1;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          res_part <= res_next[WIDTH-1:1];
          carry    <= carry_next;
          cnt      <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Last bit: commit the assembled word and flags this edge.
            // A final carry of 0 means the unsigned subtraction borrowed.
            bus.diff       <= res_next;
            bus.borrow_out <= ~carry_next;
            bus.overflow   <= (a_msb ^ b_msb) & (res_next[WIDTH-1] ^ a_msb);
            bus.done       <= 1'b1;
            bus.busy       <= 1'b0;
            cnt            <= '0;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
